mac_sequencer: RTL and testbench

Job controller for the 16-bit low-power MAC. It accepts a job of `len` operand pairs, streams them into the combinational multiplier / prefix-adder datapath over a valid/ready handshake, and owns the operand-isolation and accumulator registers. It also owns saturation. When the job ends it presents the saturated result on an output handshake.

---
 rtl/mac_sequencer.sv | 142 ++++++++++++++
 tb/tb_mac_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_sequencer.sv
// mac_sequencer: job controller for the 16-bit MAC. It streams operand pairs into an external
// multiplier/adder datapath, owns the operand and accumulator registers, and saturates the result.
`default_nettype none

module mac_sequencer #(
    parameter int W     = 16,
    parameter int ACC_W = 40,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [W-1:0]     in_a_i,
    input  logic [W-1:0]     in_b_i,
    output logic [W-1:0]     dp_a_o,
    output logic [W-1:0]     dp_b_o,
    output logic [ACC_W-1:0] dp_acc_o,
    input  logic [ACC_W:0]   dp_sum_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [ACC_W-1:0] out_data_o,
    output logic             ovf_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;

    logic             hs_w;
    logic             sat_w;
    logic [ACC_W-1:0] sat_val_w;

    assign hs_w  = (state_q == S_RUN) && in_valid_i;
    assign sat_w = dp_sum_i[ACC_W] ^ dp_sum_i[ACC_W-1];

    always_comb begin
        sat_val_w = dp_sum_i[ACC_W-1:0];
        if (sat_w) begin
            sat_val_w = dp_sum_i[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;

        // The product registered on the previous edge lands now, overlapping any new handshake.
        if (pend_q) begin
            acc_d = sat_val_w;
            if (sat_w) begin
                ovf_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    cnt_d = len_i;
                    // An empty job passes through DRAIN so its result latency follows the N+1 rule.
                    state_d = (len_i != '0) ? S_RUN : S_DRAIN;
                end
            end
            S_RUN: begin
                pend_d = hs_w;
                if (hs_w) begin
                    a_d   = in_a_i;
                    b_d   = in_b_i;
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                pend_d  = 1'b0;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign in_ready_o  = (state_q == S_RUN);
    assign out_valid_o = (state_q == S_DONE);
    assign dp_a_o      = a_q;
    assign dp_b_o      = b_q;
    assign dp_acc_o    = acc_q;
    assign out_data_o  = acc_q;
    assign ovf_o       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer; models the external datapath and the saturating accumulate.
`default_nettype none

module tb_mac_sequencer;

    localparam int W     = 16;
    localparam int ACC_W = 32;
    localparam int LEN_W = 8;
    localparam longint ACC_MAXV = (64'sd1 <<< (ACC_W-1)) - 1;
    localparam longint ACC_MINV = -(64'sd1 <<< (ACC_W-1));

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    start_i;
    logic [LEN_W-1:0]        len_i;
    logic                    busy_o;
    logic                    in_valid_i;
    logic                    in_ready_o;
    logic [W-1:0]            in_a_i, in_b_i;
    logic signed [W-1:0]     dp_a_o, dp_b_o;
    logic signed [ACC_W-1:0] dp_acc_o;
    logic [ACC_W:0]          dp_sum_i;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic signed [ACC_W-1:0] out_data_o;
    logic                    ovf_o;

    logic signed [2*W-1:0]   w_prod;
    logic signed [ACC_W:0]   w_acc_x, w_prod_x;

    assign w_prod   = dp_a_o * dp_b_o;
    assign w_acc_x  = dp_acc_o;
    assign w_prod_x = w_prod;
    assign dp_sum_i = w_acc_x + w_prod_x;

    always #5 clk = ~clk;

    mac_sequencer #(.W(W), .ACC_W(ACC_W), .LEN_W(LEN_W)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .len_i       (len_i),
        .busy_o      (busy_o),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_a_i      (in_a_i),
        .in_b_i      (in_b_i),
        .dp_a_o      (dp_a_o),
        .dp_b_o      (dp_b_o),
        .dp_acc_o    (dp_acc_o),
        .dp_sum_i    (dp_sum_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .ovf_o       (ovf_o)
    );

    typedef struct {
        longint data;
        bit     ovf;
    } exp_t;

    exp_t sb[$];
    int   n_tot = 0;
    int   n_bad = 0;
    int   ja[8];
    int   jb[8];
    int   last_a = 0;
    int   last_b = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Pops the expected result whenever an output handshake is about to happen.
    always @(negedge clk) begin
        #1;
        if (rst_n && out_valid_o && out_ready_i) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", out_data_o, e.data);
                chk("out_ovf", ovf_o, e.ovf);
            end
        end
    end

    // Caller is at a negedge; pairs come from ja/jb.
    task automatic do_job(input int n, input bit bub, input bit midst, input bit st_in_done);
        longint acc = 0;
        longint s;
        bit     ov  = 0;
        int     i   = 0;
        int     k   = 0;
        int     cyc = 0;
        int     exp_lat;
        bit     vld;
        exp_t   e;
        for (int j = 0; j < n; j++) begin
            s = acc + longint'(ja[j]) * longint'(jb[j]);
            if (s > ACC_MAXV) begin
                acc = ACC_MAXV; ov = 1;
            end else if (s < ACC_MINV) begin
                acc = ACC_MINV; ov = 1;
            end else begin
                acc = s;
            end
        end
        e.data = acc;
        e.ovf  = ov;
        sb.push_back(e);
        exp_lat = n + ((bub && n > 0) ? n - 1 : 0) + 1;

        start_i = 1'b1;
        len_i   = LEN_W'(n);
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        while (i < n && cyc < 100) begin
            vld        = !(bub && k[0]);
            start_i    = midst && (k == 1);
            len_i      = (midst && k == 1) ? LEN_W'(7) : LEN_W'(n);
            in_valid_i = vld;
            in_a_i     = vld ? W'(ja[i]) : 16'h5A5A;
            in_b_i     = vld ? W'(jb[i]) : 16'hA5A5;
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start_i = 1'b0;
            if (vld) begin
                last_a = ja[i];
                last_b = jb[i];
                i++;
            end
            chk("dp_a", dp_a_o, last_a);
            chk("dp_b", dp_b_o, last_b);
            k++;
        end
        in_valid_i = 1'b0;
        while (!out_valid_o && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        chk("latency", cyc, exp_lat);
        if (out_ready_i) begin
            if (st_in_done) begin
                start_i = 1'b1;
                len_i   = LEN_W'(1);
            end
            @(posedge clk);
            @(negedge clk);
            chk("out_valid_drop", out_valid_o, 0);
            if (st_in_done) chk("busy_after_done_start", busy_o, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n       = 1'b0;
        start_i     = 1'b0;
        len_i       = '0;
        in_valid_i  = 1'b0;
        in_a_i      = '0;
        in_b_i      = '0;
        out_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_in_ready", in_ready_o, 0);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_ovf", ovf_o, 0);
        chk("rst_dp_a", dp_a_o, 0);
        chk("rst_dp_b", dp_b_o, 0);
        chk("rst_acc", dp_acc_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic job, continuous input.
        ja = '{1, 3, -5, 7, 0, 0, 0, 0};
        jb = '{2, 4, 6, -8, 0, 0, 0, 0};
        do_job(4, 0, 0, 0);
        chk("acc_hold_idle", out_data_o, -72);

        // Same job with a bubble every other cycle.
        do_job(4, 1, 0, 0);

        // Positive saturation, then a clean job clears ovf.
        ja = '{-32768, -32768, 1, 0, 0, 0, 0, 0};
        jb = '{-32768, -32768, 1, 0, 0, 0, 0, 0};
        do_job(3, 0, 0, 0);
        chk("sat_ovf_idle", ovf_o, 1);
        ja = '{2, 0, 0, 0, 0, 0, 0, 0};
        jb = '{3, 0, 0, 0, 0, 0, 0, 0};
        do_job(1, 0, 0, 0);

        // Negative saturation.
        ja = '{-32768, -32768, -32768, 0, 0, 0, 0, 0};
        jb = '{32767, 32767, 32767, 0, 0, 0, 0, 0};
        do_job(3, 0, 0, 0);

        // Empty job held in DONE with start pulses ignored.
        out_ready_i = 1'b0;
        do_job(0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            start_i = 1'b1;
            len_i   = LEN_W'(5);
            @(posedge clk);
            @(negedge clk);
            chk("hold_out_valid", out_valid_o, 1);
            chk("hold_out_data", out_data_o, 0);
            chk("hold_busy", busy_o, 1);
        end
        start_i     = 1'b0;
        out_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("len0_released", out_valid_o, 0);
        chk("len0_idle_busy", busy_o, 0);

        // start pulsed mid-run with a different len is ignored.
        ja = '{1, 3, -5, 7, 0, 0, 0, 0};
        jb = '{2, 4, 6, -8, 0, 0, 0, 0};
        do_job(4, 0, 1, 0);

        // Asynchronous reset after two of four pairs.
        start_i = 1'b1;
        len_i   = LEN_W'(4);
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_valid_i = 1'b1;
            in_a_i     = 16'd10;
            in_b_i     = 16'd20;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid_i = 1'b0;
        chk("pre_rst_busy", busy_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy_o, 0);
        chk("arst_in_ready", in_ready_o, 0);
        chk("arst_dp_a", dp_a_o, 0);
        chk("arst_dp_b", dp_b_o, 0);
        chk("arst_acc", out_data_o, 0);
        last_a = 0;
        last_b = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ja = '{5, 0, 0, 0, 0, 0, 0, 0};
        jb = '{5, 0, 0, 0, 0, 0, 0, 0};
        do_job(1, 0, 0, 0);

        // Back-to-back: start held in DONE is ignored, taken in the following IDLE cycle.
        ja = '{-100, 0, 0, 0, 0, 0, 0, 0};
        jb = '{300, 0, 0, 0, 0, 0, 0, 0};
        do_job(1, 0, 0, 1);
        ja = '{9, 0, 0, 0, 0, 0, 0, 0};
        jb = '{-4, 0, 0, 0, 0, 0, 0, 0};
        do_job(1, 0, 0, 0);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
